// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the execute-to-writeback stage.
//   wb_state_t : load sequencer state (IDLE, LOAD_WAIT)
//   REG_ADDR_W / DOMAIN_W / MEM_ADDR_W : register, residue-domain and
//                memory-address widths
//   LAT_CNT_W  : width of the memory-latency countdown (MEM_LAT is 1..4)
//   src_hit()  : does any ID source operand name a given register
package wb_stage_pkg;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } wb_state_t;

  localparam int REG_ADDR_W = 4;
  localparam int DOMAIN_W   = 8;
  localparam int MEM_ADDR_W = 8;
  localparam int LAT_CNT_W  = 2;

  // Source 3 is only 3 bits wide in ID; it is zero-extended so that it can
  // only ever match registers 0..7.
  function automatic logic src_hit(
    input logic [REG_ADDR_W-1:0] op1,
    input logic [REG_ADDR_W-1:0] op2,
    input logic [2:0]            op3,
    input logic [REG_ADDR_W-1:0] dest
  );
    return (op1 == dest) || (op2 == dest) || ({1'b0, op3} == dest);
  endfunction

endpackage

// File: rtl/wb_load_ctrl.sv
// Load sequencer for wb_stage: two-state FSM plus the memory-latency
// countdown.
//   clk, rst        : clock, synchronous active-high reset
//   ex_valid/flush  : EX instruction presence and kill
//   ex_load         : EX instruction is a load
//   ex_dest_addr    : destination register, latched for loads
//   ex_ready        : stage can take the EX instruction (IDLE only)
//   accept          : EX instruction is taken this cycle
//   mem_rd_en       : read strobe, raised in the load accept cycle
//   capture         : memory data is valid now; write it back at the edge
//   pend_dest       : destination of the load in flight
//   state           : current FSM state, exported for observation
module wb_load_ctrl
  import wb_stage_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic                  ex_flush,
  input  logic                  ex_load,
  input  logic [REG_ADDR_W-1:0] ex_dest_addr,
  output logic                  ex_ready,
  output logic                  accept,
  output logic                  mem_rd_en,
  output logic                  capture,
  output logic [REG_ADDR_W-1:0] pend_dest,
  output wb_state_t             state
);

  wb_state_t             state_q, state_d;
  logic [LAT_CNT_W-1:0]  count_q, count_d;
  logic [REG_ADDR_W-1:0] pend_q, pend_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pend_d    = pend_q;
    ex_ready  = 1'b0;
    accept    = 1'b0;
    mem_rd_en = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        ex_ready = 1'b1;
        accept   = ex_valid & ~ex_flush;
        if (accept && ex_load) begin
          mem_rd_en = 1'b1;
          pend_d    = ex_dest_addr;
          // The counter reaches zero in the cycle the read data is valid.
          count_d   = LAT_CNT_W'(MEM_LAT - 1);
          state_d   = LOAD_WAIT;
        end
      end
      LOAD_WAIT: begin
        // A load in flight is never cancelled; EX input is ignored here.
        if (count_q == '0) begin
          capture = 1'b1;
          state_d = IDLE;
        end else begin
          count_d = count_q - LAT_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pend_dest = pend_q;
  assign state     = state_q;

endmodule

// File: rtl/wb_stage.sv
// Execute-to-writeback stage: registers ALU results, sequences data-memory
// loads, drives the register-file write port and flags load-use hazards.
//   clk, rst                  : clock, synchronous active-high reset
//   ex_*                      : instruction from EX (valid/flush/wr_en/load,
//                               destination, ALU result, load address)
//   ex_ready                  : stage can accept the EX instruction
//   mem_rd_en/addr, mem_rd_data : data-memory read port (MEM_LAT cycles)
//   op1/op2/op3_addr_IFID     : source registers of the instruction in ID
//   load_hazard               : stall IF/ID and insert a bubble
//   wr_data, destination_reg_addr, reg_wr_en : register-file write port
//
// Handshake: the EX instruction is taken in any cycle where
// ex_valid & ~ex_flush & ex_ready; ex_ready depends only on stage state,
// never on ex_valid, and EX must hold its instruction while ex_ready is low.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int NUM_DOMAINS = 1,
  parameter int MEM_LAT     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ex_valid,
  input  logic                          ex_flush,
  input  logic                          ex_wr_en,
  input  logic                          ex_load,
  input  logic [REG_ADDR_W-1:0]         ex_dest_addr,
  input  logic [NUM_DOMAINS*DOMAIN_W-1:0] ex_result,
  input  logic [MEM_ADDR_W-1:0]         ex_mem_addr,
  output logic                          ex_ready,
  output logic                          mem_rd_en,
  output logic [MEM_ADDR_W-1:0]         mem_rd_addr,
  input  logic [NUM_DOMAINS*DOMAIN_W-1:0] mem_rd_data,
  input  logic [REG_ADDR_W-1:0]         op1_addr_IFID,
  input  logic [REG_ADDR_W-1:0]         op2_addr_IFID,
  input  logic [2:0]                    op3_addr_IFID,
  output logic                          load_hazard,
  output logic [NUM_DOMAINS*DOMAIN_W-1:0] wr_data,
  output logic [REG_ADDR_W-1:0]         destination_reg_addr,
  output logic                          reg_wr_en
);

  localparam int W = NUM_DOMAINS * DOMAIN_W;

  logic                  accept;
  logic                  capture;
  logic [REG_ADDR_W-1:0] pend_dest;
  wb_state_t             state;
  // Marks a write-back cycle that carries load data.
  logic                  wb_is_load;

  wb_load_ctrl #(
    .MEM_LAT (MEM_LAT)
  ) u_load_ctrl (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_flush     (ex_flush),
    .ex_load      (ex_load),
    .ex_dest_addr (ex_dest_addr),
    .ex_ready     (ex_ready),
    .accept       (accept),
    .mem_rd_en    (mem_rd_en),
    .capture      (capture),
    .pend_dest    (pend_dest),
    .state        (state)
  );

  assign mem_rd_addr = ex_mem_addr;

  // Write port: one-cycle reg_wr_en pulse; data and address only change
  // when a write actually happens, so they hold while reg_wr_en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_wr_en            <= 1'b0;
      wr_data              <= '0;
      destination_reg_addr <= '0;
      wb_is_load           <= 1'b0;
    end else begin
      reg_wr_en  <= 1'b0;
      wb_is_load <= 1'b0;
      if (capture) begin
        reg_wr_en            <= 1'b1;
        wr_data              <= mem_rd_data;
        destination_reg_addr <= pend_dest;
        wb_is_load           <= 1'b1;
      end else if (accept && !ex_load && ex_wr_en) begin
        reg_wr_en            <= 1'b1;
        wr_data              <= W'(ex_result);
        destination_reg_addr <= ex_dest_addr;
      end
    end
  end

  // Load results are not forwarded, so a dependent ID instruction stalls
  // from the load accept cycle until the register file has been written.
  // The write-back cycle itself is included because ID reads the register
  // file in the same cycle the write lands.
  always_comb begin
    load_hazard = 1'b0;
    if (accept && ex_load &&
        src_hit(op1_addr_IFID, op2_addr_IFID, op3_addr_IFID, ex_dest_addr))
      load_hazard = 1'b1;
    if (state == LOAD_WAIT &&
        src_hit(op1_addr_IFID, op2_addr_IFID, op3_addr_IFID, pend_dest))
      load_hazard = 1'b1;
    if (wb_is_load &&
        src_hit(op1_addr_IFID, op2_addr_IFID, op3_addr_IFID, destination_reg_addr))
      load_hazard = 1'b1;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Execute-to-writeback pipeline stage. It registers ALU results and sequences data-memory loads.
- It drives the register-file write port: wr_data, destination_reg_addr, reg_wr_en. The forwarding unit consumes these same signals.
- It raises a load-use hazard toward IF/ID. The forwarding unit never bypasses load results, so dependent instructions must wait for the register-file write.

Parameters:
- NUM_DOMAINS, 1, number of 8-bit residue domains; datapath width is NUM_DOMAINS*8.
- MEM_LAT, 1, data-memory read latency in cycles; legal range 1..4.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- ex_valid  in  1  EX holds a valid instruction.
- ex_flush  in  1  kill the EX instruction this cycle.
- ex_wr_en  in  1  instruction writes a register.
- ex_load  in  1  instruction is a load.
- ex_dest_addr  in  4  destination register.
- ex_result  in  NUM_DOMAINS*8  ALU result.
- ex_mem_addr  in  8  load address.
- ex_ready  out  1  stage can accept the EX instruction.
- mem_rd_en  out  1  data-memory read strobe.
- mem_rd_addr  out  8  data-memory read address.
- mem_rd_data  in  NUM_DOMAINS*8  data-memory read data; valid MEM_LAT cycles after mem_rd_en.
- op1_addr_IFID  in  4  ID source 1.
- op2_addr_IFID  in  4  ID source 2.
- op3_addr_IFID  in  3  ID source 3; zero-extended before compare.
- load_hazard  out  1  stall IF/ID and insert a bubble.
- wr_data  out  NUM_DOMAINS*8  write-back data.
- destination_reg_addr  out  4  write-back register.
- reg_wr_en  out  1  register-file write enable.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE, counter = 0.
  - reg_wr_en = 0, wr_data = 0, destination_reg_addr = 0.
  - load_hazard = 0, mem_rd_en = 0.
- Reset asserted mid-load aborts the load. No write-back occurs and no pending hazard remains.
- Accept condition: accept = ex_valid & ~ex_flush & ex_ready. ex_ready = (state == IDLE), combinational.
- States: IDLE, LOAD_WAIT.
- Non-load accept (ex_load = 0):
  - At the next edge, reg_wr_en = ex_wr_en.
  - At the same edge, wr_data = ex_result and destination_reg_addr = ex_dest_addr.
  - Latency is 1 cycle. Back-to-back accepts are allowed every cycle.
- Load accept:
  - mem_rd_en = 1 combinationally in the accept cycle; mem_rd_addr = ex_mem_addr.
  - ex_dest_addr is latched into pend_dest.
  - State moves to LOAD_WAIT with counter = MEM_LAT-1.
  - ex_wr_en is ignored; loads always write.
- LOAD_WAIT:
  - ex_ready = 0; EX holds its instruction, and ex_valid is ignored.
  - If counter == 0: sample mem_rd_data into wr_data, set destination_reg_addr = pend_dest and reg_wr_en = 1, and return to IDLE.
  - Otherwise decrement counter.
  - A load accepted at cycle k writes back with reg_wr_en high during cycle k+MEM_LAT+1.
- reg_wr_en is a one-cycle pulse per instruction.
- wr_data and destination_reg_addr hold their last values while reg_wr_en = 0.
- ex_flush:
  - Suppresses acceptance in IDLE, giving no write and no memory read.
  - Has no effect in LOAD_WAIT, since a load in flight is never cancelled.
- load_hazard is combinational: any IFID source matches the load destination, where the load destination is:
  - ex_dest_addr when a load is being accepted this cycle;
  - pend_dest while in LOAD_WAIT.
- load_hazard also stays high in the write-back cycle if a source matches destination_reg_addr of a load write. This covers the ID-read versus write race. It requires a registered flag wb_is_load.
- Register address 0 has no special meaning; it is compared and written like any other register.
- ex_result arithmetic is passed through unmodified; no width conversion is done per domain.

Decomposition:
- Shared package:
  - wb_state_t enum {IDLE, LOAD_WAIT};
  - REG_ADDR_W = 4;
  - DOMAIN_W = 8;
  - MEM_ADDR_W = 8.
- One sub-module, wb_load_ctrl: the FSM plus the latency counter. Outputs: ex_ready, mem_rd_en, the capture strobe, and pend_dest.

Test Plan:
1. ALU write path:
   - Stimulus: reset, then accept ex_wr_en = 1, dest = 5, result = 0x3C.
   - Response: next cycle reg_wr_en = 1, destination_reg_addr = 5, wr_data = 0x3C; reg_wr_en = 0 the cycle after.
2. Load with MEM_LAT = 2:
   - Stimulus: load to r7 at 0x10, memory returns 0xA5.
   - Response: mem_rd_en = 1, mem_rd_addr = 0x10 at cycle k; ex_ready = 0 for cycles k+1..k+2; reg_wr_en = 1, wr_data = 0xA5, destination_reg_addr = 7 at cycle k+3.
3. Load-use:
   - Stimulus: load to r3 in flight, ID op2_addr = 3.
   - Response: load_hazard = 1 from the accept cycle through the write-back cycle, then 0.
   - Control: an unrelated op1_addr = 4 gives load_hazard = 0.
4. Flush:
   - Stimulus: ex_valid = 1, ex_flush = 1, with a load or ALU instruction.
   - Response: no mem_rd_en, reg_wr_en stays 0, state stays IDLE.
5. Reset mid-load:
   - Stimulus: rst asserted in LOAD_WAIT.
   - Response: next cycle state = IDLE, ex_ready = 1, reg_wr_en = 0, load_hazard = 0; no write-back follows.
6. NUM_DOMAINS = 3:
   - Stimulus: back-to-back ALU writes with 0x010203 then 0x0A0B0C.
   - Response: consecutive reg_wr_en pulses carrying the full 24-bit values.
